// File: rtl/dmem_arbiter.sv
// dmem_arbiter: weighted round-robin arbiter of two requesters onto one sync-read memory port, with IO write decode
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64,
  parameter int MAX_BURST = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              io_write,
  output logic [DATA_W-1:0] io_data,
  output logic              io_src
);
  localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  logic ptr, rd_pend, rd_src, any, sel, other, io_hit;
  logic [CW-1:0] cnt;
  always_comb begin
    any = (req0 | req1) & ~rst;
    sel = (ptr ? req1 : req0) ? ptr : ~ptr;
    other = sel ? req0 : req1;
    gnt0 = any & ~sel;
    gnt1 = any & sel;
    mem_en = any;
    mem_we = any & (sel ? we1 : we0);
    mem_addr = any ? (sel ? addr1 : addr0) : '0;
    mem_wdata = any ? (sel ? wdata1 : wdata0) : '0;
    io_hit = mem_we & (mem_addr == IO_ADDR);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
      cnt <= '0;
      rd_pend <= 1'b0;
      rd_src <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      io_write <= 1'b0;
      io_data <= '0;
      io_src <= 1'b0;
    end else begin
      rd_pend <= any & ~mem_we;
      rd_src <= sel;
      rvalid0 <= rd_pend & ~rd_src;
      rvalid1 <= rd_pend & rd_src;
      if (rd_pend && !rd_src) rdata0 <= mem_rdata;
      if (rd_pend && rd_src) rdata1 <= mem_rdata;
      io_write <= io_hit;
      io_data <= io_hit ? mem_wdata : '0;
      if (io_hit) io_src <= sel;
      // cnt only advances while the other requester is waiting
      if (any) begin
        if (sel != ptr) begin
          ptr <= sel;
          cnt <= '0;
        end else if (other) begin
          ptr <= (cnt == CW'(MAX_BURST - 1)) ? ~ptr : ptr;
          cnt <= (cnt == CW'(MAX_BURST - 1)) ? '0 : cnt + 1'b1;
        end else cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven check of arbitration, read routing, IO decode and reset behaviour
module tb_dmem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [7:0] addr0 = 0, addr1 = 0;
  logic [63:0] wdata0 = 0, wdata1 = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, io_write, io_src;
  logic [63:0] rdata0, rdata1, mem_wdata, io_data;
  logic [63:0] mem_rdata = 0;
  logic [7:0] mem_addr;
  logic [63:0] mem [256];
  int n_chk = 0, n_err = 0, cur = -1;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .io_write(io_write), .io_data(io_data), .io_src(io_src)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end

  typedef struct {
    logic [1:0] c0; logic [7:0] a0; logic [63:0] d0;
    logic [1:0] c1; logic [7:0] a1; logic [63:0] d1;
    logic [1:0] g; logic [1:0] v; logic [63:0] q0; logic [63:0] q1;
    logic iw; logic [63:0] id; logic is;
  } vec_t;

  localparam logic [1:0] IDL = 2'b00, RD = 2'b10, WR = 2'b11;
  localparam logic [1:0] NO = 2'b00, P0 = 2'b01, P1 = 2'b10;
  localparam logic [63:0] Z = 64'h0;
  vec_t tbl [35];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %h expected %h", n, cur, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] c0, input logic [7:0] a0, input logic [63:0] d0,
                       input logic [1:0] c1, input logic [7:0] a1, input logic [63:0] d1);
    req0 = c0[1]; we0 = c0[0]; addr0 = a0; wdata0 = d0;
    req1 = c1[1]; we1 = c1[0]; addr1 = a1; wdata1 = d1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'h100 + 64'(i);
    tbl[0]  = '{IDL, 8'h00, Z, IDL, 8'h00, Z, NO, NO, Z, Z, 1'b0, Z, 1'b0};
    tbl[1]  = '{IDL, 8'h00, Z, IDL, 8'h00, Z, NO, NO, Z, Z, 1'b0, Z, 1'b0};
    tbl[2]  = '{WR, 8'h10, 64'h1234, IDL, 8'h00, Z, P0, NO, Z, Z, 1'b0, Z, 1'b0};
    tbl[3]  = '{RD, 8'h10, Z, IDL, 8'h00, Z, P0, NO, Z, Z, 1'b0, Z, 1'b0};
    tbl[4]  = '{IDL, 8'h00, Z, IDL, 8'h00, Z, NO, NO, Z, Z, 1'b0, Z, 1'b0};
    tbl[5]  = '{IDL, 8'h00, Z, IDL, 8'h00, Z, NO, P0, 64'h1234, Z, 1'b0, Z, 1'b0};
    tbl[6]  = '{IDL, 8'h00, Z, IDL, 8'h00, Z, NO, NO, 64'h1234, Z, 1'b0, Z, 1'b0};
    tbl[7]  = '{RD, 8'h20, Z, RD, 8'h30, Z, P0, NO, 64'h1234, Z, 1'b0, Z, 1'b0};
    tbl[8]  = '{RD, 8'h21, Z, RD, 8'h30, Z, P0, NO, 64'h1234, Z, 1'b0, Z, 1'b0};
    tbl[9]  = '{RD, 8'h22, Z, RD, 8'h30, Z, P1, P0, 64'h120, Z, 1'b0, Z, 1'b0};
    tbl[10] = '{RD, 8'h22, Z, RD, 8'h31, Z, P1, P0, 64'h121, Z, 1'b0, Z, 1'b0};
    tbl[11] = '{RD, 8'h22, Z, RD, 8'h32, Z, P0, P1, 64'h121, 64'h130, 1'b0, Z, 1'b0};
    tbl[12] = '{RD, 8'h23, Z, RD, 8'h32, Z, P0, P1, 64'h121, 64'h131, 1'b0, Z, 1'b0};
    tbl[13] = '{IDL, 8'h00, Z, IDL, 8'h00, Z, NO, P0, 64'h122, 64'h131, 1'b0, Z, 1'b0};
    tbl[14] = '{IDL, 8'h00, Z, IDL, 8'h00, Z, NO, P0, 64'h123, 64'h131, 1'b0, Z, 1'b0};
    tbl[15] = '{IDL, 8'h00, Z, IDL, 8'h00, Z, NO, NO, 64'h123, 64'h131, 1'b0, Z, 1'b0};
    tbl[16] = '{RD, 8'h24, Z, IDL, 8'h00, Z, P0, NO, 64'h123, 64'h131, 1'b0, Z, 1'b0};
    tbl[17] = '{IDL, 8'h00, Z, IDL, 8'h00, Z, NO, NO, 64'h123, 64'h131, 1'b0, Z, 1'b0};
    tbl[18] = '{IDL, 8'h00, Z, RD, 8'h40, Z, P1, P0, 64'h124, 64'h131, 1'b0, Z, 1'b0};
    tbl[19] = '{IDL, 8'h00, Z, RD, 8'h41, Z, P1, NO, 64'h124, 64'h131, 1'b0, Z, 1'b0};
    tbl[20] = '{IDL, 8'h00, Z, RD, 8'h42, Z, P1, P1, 64'h124, 64'h140, 1'b0, Z, 1'b0};
    tbl[21] = '{RD, 8'h25, Z, RD, 8'h43, Z, P1, P1, 64'h124, 64'h141, 1'b0, Z, 1'b0};
    tbl[22] = '{RD, 8'h25, Z, RD, 8'h44, Z, P1, P1, 64'h124, 64'h142, 1'b0, Z, 1'b0};
    tbl[23] = '{RD, 8'h25, Z, RD, 8'h45, Z, P0, P1, 64'h124, 64'h143, 1'b0, Z, 1'b0};
    tbl[24] = '{RD, 8'h26, Z, RD, 8'h45, Z, P0, P1, 64'h124, 64'h144, 1'b0, Z, 1'b0};
    tbl[25] = '{IDL, 8'h00, Z, IDL, 8'h00, Z, NO, P0, 64'h125, 64'h144, 1'b0, Z, 1'b0};
    tbl[26] = '{IDL, 8'h00, Z, IDL, 8'h00, Z, NO, P0, 64'h126, 64'h144, 1'b0, Z, 1'b0};
    tbl[27] = '{IDL, 8'h00, Z, WR, 8'hFF, 64'hDEADBEEF, P1, NO, 64'h126, 64'h144, 1'b0, Z, 1'b0};
    tbl[28] = '{IDL, 8'h00, Z, IDL, 8'h00, Z, NO, NO, 64'h126, 64'h144, 1'b1, 64'hDEADBEEF, 1'b1};
    tbl[29] = '{IDL, 8'h00, Z, WR, 8'hFE, 64'h55, P1, NO, 64'h126, 64'h144, 1'b0, Z, 1'b1};
    tbl[30] = '{IDL, 8'h00, Z, IDL, 8'h00, Z, NO, NO, 64'h126, 64'h144, 1'b0, Z, 1'b1};
    tbl[31] = '{RD, 8'hFF, Z, IDL, 8'h00, Z, P0, NO, 64'h126, 64'h144, 1'b0, Z, 1'b1};
    tbl[32] = '{WR, 8'hFF, 64'h77, IDL, 8'h00, Z, P0, NO, 64'h126, 64'h144, 1'b0, Z, 1'b1};
    tbl[33] = '{IDL, 8'h00, Z, IDL, 8'h00, Z, NO, P0, 64'hDEADBEEF, 64'h144, 1'b1, 64'h77, 1'b0};
    tbl[34] = '{IDL, 8'h00, Z, IDL, 8'h00, Z, NO, NO, 64'hDEADBEEF, 64'h144, 1'b0, Z, 1'b0};

    #12;
    chk("rst_gnt0", 64'(gnt0), Z);
    chk("rst_mem_en", 64'(mem_en), Z);
    chk("rst_rdata0", rdata0, Z);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("idle_mem_en", 64'(mem_en), Z);
      chk("idle_rvalid", 64'({rvalid1, rvalid0}), Z);
      chk("idle_io_write", 64'(io_write), Z);
    end

    for (int k = 0; k < 35; k++) begin
      cur = k;
      @(negedge clk);
      drive(tbl[k].c0, tbl[k].a0, tbl[k].d0, tbl[k].c1, tbl[k].a1, tbl[k].d1);
      #1;
      chk("gnt", 64'({gnt1, gnt0}), 64'(tbl[k].g));
      chk("mem_en", 64'(mem_en), 64'(|tbl[k].g));
      chk("mem_we", 64'(mem_we), 64'((tbl[k].g[0] & tbl[k].c0[0]) | (tbl[k].g[1] & tbl[k].c1[0])));
      if (|tbl[k].g) chk("mem_addr", 64'(mem_addr), 64'(tbl[k].g[1] ? tbl[k].a1 : tbl[k].a0));
      chk("rvalid", 64'({rvalid1, rvalid0}), 64'(tbl[k].v));
      chk("rdata0", rdata0, tbl[k].q0);
      chk("rdata1", rdata1, tbl[k].q1);
      chk("io_write", 64'(io_write), 64'(tbl[k].iw));
      chk("io_data", io_data, tbl[k].id);
      chk("io_src", 64'(io_src), 64'(tbl[k].is));
    end

    // asynchronous reset mid-cycle clears a pending IO pulse and combinational grant
    cur = 100;
    @(negedge clk) drive(WR, 8'hFF, 64'h99, IDL, 8'h00, Z);
    @(posedge clk); #1;
    drive(RD, 8'h10, Z, IDL, 8'h00, Z);
    #1;
    chk("pre_rst_io_write", 64'(io_write), 64'h1);
    chk("pre_rst_gnt0", 64'(gnt0), 64'h1);
    rst = 1'b1;
    #1;
    chk("async_gnt0", 64'(gnt0), Z);
    chk("async_mem_en", 64'(mem_en), Z);
    chk("async_io_write", 64'(io_write), Z);
    chk("async_io_data", io_data, Z);
    chk("async_rdata0", rdata0, Z);
    drive(IDL, 8'h00, Z, IDL, 8'h00, Z);
    @(negedge clk) rst = 1'b0;

    // read in flight, then a reset pulse before its response edge
    cur = 200;
    @(negedge clk) drive(IDL, 8'h00, Z, RD, 8'h30, Z);
    #1 chk("inflight_gnt1", 64'(gnt1), 64'h1);
    @(posedge clk); #1 rst = 1'b1;
    #2 rst = 1'b0;
    drive(IDL, 8'h00, Z, IDL, 8'h00, Z);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("dropped_rvalid1", 64'({rvalid1, rvalid0}), Z);
    end
    @(negedge clk) drive(RD, 8'h10, Z, RD, 8'h31, Z);
    #1 chk("ptr_reset_gnt", 64'({gnt1, gnt0}), 64'(P0));
    @(negedge clk) drive(IDL, 8'h00, Z, RD, 8'h31, Z);
    #1 chk("post_rst_gnt1", 64'({gnt1, gnt0}), 64'(P1));
    @(negedge clk) drive(IDL, 8'h00, Z, IDL, 8'h00, Z);
    #1;
    chk("post_rst_rvalid0", 64'({rvalid1, rvalid0}), 64'(P0));
    chk("post_rst_rdata0", rdata0, 64'h1234);
    @(negedge clk); #1;
    chk("post_rst_rvalid1", 64'({rvalid1, rvalid0}), 64'(P1));
    chk("post_rst_rdata1", rdata1, 64'h131);
    @(negedge clk); #1;
    chk("post_rst_quiet", 64'({rvalid1, rvalid0}), Z);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
